// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues req/ack fetches to a multi-cycle
// instruction memory and presents fetched words to IF/ID with a valid/stall handshake.
module fetch_sequencer #(
  parameter int                     ADDRESS_LEN = 32,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0,
  parameter int                     MAX_WAIT    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hazard_stall,
  input  logic                   branch_taken,
  input  logic [ADDRESS_LEN-1:0] branch_address,
  output logic                   imem_req,
  output logic [ADDRESS_LEN-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [ADDRESS_LEN-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [ADDRESS_LEN-1:0] if_pc,
  output logic [ADDRESS_LEN-1:0] if_instruction,
  output logic                   flush_out,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e                 state_q, state_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [ADDRESS_LEN-1:0] rpc_q, rpc_d;
  logic                   pend_q, pend_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic [ADDRESS_LEN-1:0] addr_q, addr_d;
  logic                   vld_q, vld_d;
  logic [ADDRESS_LEN-1:0] ifpc_q, ifpc_d;
  logic [ADDRESS_LEN-1:0] instr_q, instr_d;
  logic                   flush_q, flush_d;
  logic                   tout_q, tout_d;
  logic [ADDRESS_LEN-1:0] tgt;

  assign tgt = {branch_address[ADDRESS_LEN-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    vld_d   = vld_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    flush_d = 1'b0;
    tout_d  = tout_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        cnt_d   = '0;
        pc_d    = branch_taken ? tgt : pc_q;
        addr_d  = branch_taken ? tgt : pc_q;
      end
      REQ: begin
        if (imem_ack) begin
          cnt_d = '0;
          if (branch_taken || pend_q) begin
            // The returned word belongs to a killed path; refetch at the redirect.
            pc_d    = branch_taken ? tgt : rpc_q;
            addr_d  = branch_taken ? tgt : rpc_q;
            pend_d  = 1'b0;
            flush_d = branch_taken;
          end else begin
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            pc_d    = pc_q + ADDRESS_LEN'(4);
            vld_d   = 1'b1;
            req_d   = 1'b0;
            state_d = VALID;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (branch_taken) begin
            pend_d  = 1'b1;
            rpc_d   = tgt;
            flush_d = 1'b1;
          end
          if (cnt_q + 8'd1 == MaxWait) begin
            state_d = ERR;
            req_d   = 1'b0;
            tout_d  = 1'b1;
            pend_d  = 1'b0;
            flush_d = 1'b0;
          end
        end
      end
      VALID: begin
        if (branch_taken) begin
          vld_d   = 1'b0;
          flush_d = 1'b1;
          pc_d    = tgt;
          addr_d  = tgt;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end else if (!hazard_stall) begin
          vld_d   = 1'b0;
          addr_d  = pc_q;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      ERR: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      rpc_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      ifpc_q  <= '0;
      instr_q <= '0;
      flush_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
      flush_q <= flush_d;
      tout_q  <= tout_d;
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign if_valid       = vld_q;
  assign if_pc          = ifpc_q;
  assign if_instruction = instr_q;
  assign flush_out      = flush_q;
  assign timeout_err    = tout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory responses driven inline, presented
// instructions checked against a scoreboard filled when each ack is driven.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, hazard_stall, branch_taken, imem_ack;
  logic [31:0] branch_address, imem_rdata;
  logic        imem_req, if_valid, flush_out, timeout_err;
  logic [31:0] imem_addr, if_pc, if_instruction;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t sb[$];
  int     checks = 0;
  int     fails  = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
    .if_instruction(if_instruction), .flush_out(flush_out), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_vld"}, if_valid, 0);
    chk({tag, "_flush"}, flush_out, 0);
    chk({tag, "_tout"}, timeout_err, 0);
  endtask

  // Bounded wait for a request, then answer after lat REQ cycles (lat=1: same cycle).
  task automatic serve(input int lat, input logic [31:0] a, input string tag);
    fetch_t e;
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_req"}, imem_req, 1);
    chk({tag, "_addr"}, imem_addr, a);
    for (int i = 1; i < lat; i++) begin
      tick;
      chk({tag, "_addr_hold"}, imem_addr, a);
    end
    imem_ack   = 1'b1;
    imem_rdata = word(a);
    sb.push_back('{pc: a, instr: word(a)});
    tick;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_vld"}, if_valid, 1);
      chk({tag, "_pc"}, if_pc, e.pc);
      chk({tag, "_instr"}, if_instruction, e.instr);
      chk({tag, "_req_off"}, imem_req, 0);
    end
  endtask

  task automatic next_req(input logic [31:0] a, input string tag);
    tick;
    chk({tag, "_vld_drop"}, if_valid, 0);
    chk({tag, "_req"}, imem_req, 1);
    chk({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b1; hazard_stall = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    branch_address = '0; imem_rdata = '0;
    tick; tick;
    chk_idle_outs("reset");
    chk("reset_pc", if_pc, 0);
    rst = 1'b0;
    tick;
    chk("first_req", imem_req, 1);

    // Steady fetch, two-cycle memory: one instruction every three cycles.
    serve(2, 32'h0, "f0");
    next_req(32'h4, "n4");
    serve(2, 32'h4, "f4");
    next_req(32'h8, "n8");
    serve(2, 32'h8, "f8");

    hazard_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_vld", if_valid, 1);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_instr", if_instruction, word(32'h8));
      chk("stall_req", imem_req, 0);
    end
    hazard_stall = 1'b0;
    next_req(32'hC, "nC");
    serve(2, 32'hC, "fC");
    next_req(32'h10, "n10");

    // Redirect while the fetch is in flight: late word is discarded.
    branch_taken = 1'b1; branch_address = 32'h100;
    tick;
    branch_taken = 1'b0;
    chk("kill_flush", flush_out, 1);
    chk("kill_addr_hold", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_rdata = word(32'h10);
    tick;
    imem_ack = 1'b0;
    chk("kill_discard_vld", if_valid, 0);
    chk("kill_flush_end", flush_out, 0);
    chk("kill_req", imem_req, 1);
    chk("kill_new_addr", imem_addr, 32'h100);
    serve(1, 32'h100, "f100");

    // Redirect while presenting and stalled, target low bits masked.
    hazard_stall = 1'b1; branch_taken = 1'b1; branch_address = 32'h203;
    tick;
    hazard_stall = 1'b0; branch_taken = 1'b0;
    chk("vbr_flush", flush_out, 1);
    chk("vbr_vld", if_valid, 0);
    chk("vbr_addr", imem_addr, 32'h200);
    serve(1, 32'h200, "f200");

    // PC wrap at the top of the address space.
    branch_taken = 1'b1; branch_address = 32'hFFFF_FFFF;
    tick;
    branch_taken = 1'b0;
    serve(1, 32'hFFFF_FFFC, "ftop");
    next_req(32'h0, "wrap");

    // No ack: timeout after MAX_WAIT cycles in REQ.
    repeat (14) tick;
    chk("pre_tout_req", imem_req, 1);
    chk("pre_tout_err", timeout_err, 0);
    tick;
    chk("tout_err", timeout_err, 1);
    chk("tout_req", imem_req, 0);
    imem_ack = 1'b1; branch_taken = 1'b1; branch_address = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("err_sticky", timeout_err, 1);
      chk("err_req", imem_req, 0);
      chk("err_vld", if_valid, 0);
      chk("err_flush", flush_out, 0);
    end
    imem_ack = 1'b0; branch_taken = 1'b0;

    rst = 1'b1;
    tick;
    chk_idle_outs("err_reset");
    rst = 1'b0;
    tick;
    chk("rr_req", imem_req, 1);
    chk("rr_addr", imem_addr, 32'h0);
    tick;
    // Reset mid-REQ; an ack arriving afterwards belongs to the abandoned request.
    rst = 1'b1;
    tick;
    chk_idle_outs("midreq_reset");
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick;
    imem_ack = 1'b0; imem_rdata = '0;
    chk("late_ack_vld", if_valid, 0);
    chk("late_ack_req", imem_req, 1);
    chk("late_ack_addr", imem_addr, 32'h0);
    serve(1, 32'h0, "fpost");
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
